axi_slice_dc_token_reader: RTL



---
 rtl/axi_slice_dc_pkg.sv | 30 +++
 rtl/axi_slice_dc_sync.sv | 30 +++
 rtl/axi_slice_dc_token_reader.sv | 100 ++++++++++
 3 files changed

// File: rtl/axi_slice_dc_pkg.sv
// +----------------------------------------------------------------------------
// | axi_slice_dc_pkg : shared constants and one-hot helpers for the dc reader
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package axi_slice_dc_pkg;

    localparam int DEFAULT_BUFFER_WIDTH = 8;
    localparam int DEFAULT_SYNC_STAGES  = 2;
    localparam int MAX_BUFFER_WIDTH     = 64;

    // Rotate a one-hot vector left by one inside the low `width` bits;
    // bit width-1 wraps to bit 0 and bits at or above width stay zero.
    function automatic logic [MAX_BUFFER_WIDTH-1:0] rotate_onehot(
        input logic [MAX_BUFFER_WIDTH-1:0] v,
        input int                          width
    );
        logic [MAX_BUFFER_WIDTH-1:0] r;
        r = '0;
        for (int i = 1; i < MAX_BUFFER_WIDTH; i++) begin
            r[i] = (i < width) ? v[i-1] : 1'b0;
        end
        r[0] = v[width-1];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_slice_dc_sync.sv
// +----------------------------------------------------------------------------
// | axi_slice_dc_sync : single-bit multi-flop synchronizer, async reset to 0
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axi_slice_dc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/axi_slice_dc_token_reader.sv
// +----------------------------------------------------------------------------
// | axi_slice_dc_token_reader : reader side of a toggle-token async FIFO slice
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module axi_slice_dc_token_reader
    import axi_slice_dc_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
    parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               isolate_i,
    input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_i,
    input  logic [BUFFER_WIDTH-1:0]            writetoken_i,
    output logic [BUFFER_WIDTH-1:0]            readpointer_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [DATA_WIDTH-1:0]              data_o
);

    logic [BUFFER_WIDTH-1:0]     wt_sync;
    logic [BUFFER_WIDTH-1:0]     rp_q, rp_d;
    // Held at full package width so the shared rotate helper can be used
    // directly; bits at or above BUFFER_WIDTH remain zero.
    logic [MAX_BUFFER_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic                        valid_q, valid_d;
    logic [DATA_WIDTH-1:0]       data_q, data_d;

    logic                        w_pending;
    logic                        w_eff_rdy;
    logic                        w_load;
    logic [DATA_WIDTH-1:0]       w_slot;

    generate
        for (genvar gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_sync
            axi_slice_dc_sync #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .d_i   (writetoken_i[gi]),
                .q_o   (wt_sync[gi])
            );
        end
    endgenerate

    assign w_pending = |(rd_idx_q[BUFFER_WIDTH-1:0] & (wt_sync ^ rp_q));
    assign w_eff_rdy = ready_i | isolate_i;
    assign w_load    = w_pending & (~valid_q | w_eff_rdy);

    always_comb begin
        w_slot = '0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            if (rd_idx_q[i]) begin
                w_slot = w_slot | data_async_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        rp_d     = rp_q;
        rd_idx_d = rd_idx_q;
        if (w_load) begin
            valid_d  = 1'b1;
            data_d   = w_slot;
            rp_d     = rp_q ^ rd_idx_q[BUFFER_WIDTH-1:0];
            rd_idx_d = rotate_onehot(rd_idx_q, BUFFER_WIDTH);
        end else if (valid_q && w_eff_rdy) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            rp_q     <= '0;
            rd_idx_q <= MAX_BUFFER_WIDTH'(1);
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            rp_q     <= rp_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Isolation only masks the handshake flag; buffered data keeps draining.
    assign valid_o       = valid_q & ~isolate_i;
    assign data_o        = data_q;
    assign readpointer_o = rp_q;

endmodule

`default_nettype wire
